// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Holds the fetch PC, issues in-order word
// requests to instruction memory, and buffers the returned words together with
// their PCs in a small FIFO. The FIFO head is offered to the decoder over a
// valid/ready handshake. A redirect (taken branch / jump) flushes the FIFO,
// moves the PC and marks every request still in flight as stale so that its
// response is dropped on arrival.
//
// Parameters
//   RESET_PC     first PC fetched after reset (word aligned)
//   DEPTH        FIFO entries and maximum requests in flight (power of two, >= 2)
//
// Ports
//   clk             clock, rising edge
//   rstn            asynchronous reset, ACTIVE HIGH despite the name
//   imem_req        request valid
//   imem_addr       request byte address (word aligned)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (in order, latency >= 1)
//   imem_rdata      response instruction word
//   instr_valid     FIFO head valid
//   instr_raw       FIFO head instruction word (0 when empty)
//   instr_pc        FIFO head PC (0 when empty)
//   instr_ready     decoder accepts the head this cycle
//   redirect_valid  control-flow redirect, wins over every other event
//   redirect_pc     new fetch PC, bits [1:0] ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;      // counts 0..DEPTH
    localparam int OW = CW + 1;      // FIFO count + outstanding, 0..2*DEPTH

    // Architectural state
    logic [31:0]   pc_reg,          pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg,     discard_next;
    logic [CW-1:0] fifo_count_reg,  fifo_count_next;
    logic [AW-1:0] fifo_wr_ptr_reg, fifo_wr_ptr_next;
    logic [AW-1:0] fifo_rd_ptr_reg, fifo_rd_ptr_next;
    logic [AW-1:0] pend_wr_ptr_reg, pend_wr_ptr_next;
    logic [AW-1:0] pend_rd_ptr_reg, pend_rd_ptr_next;

    // Storage: PCs of requests in flight, and the instruction FIFO itself
    logic [31:0] pend_pc_mem   [DEPTH];
    logic [31:0] fifo_pc_mem   [DEPTH];
    logic [31:0] fifo_word_mem [DEPTH];

    // Handshake / control terms
    logic [OW-1:0] occupancy;
    logic          credit_ok;
    logic          req_fire;
    logic          fifo_pop;
    logic          fifo_push;

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    // A slot freed by a pop in this very cycle is counted as free. The response
    // that could land in it cannot arrive before next cycle, and this is what
    // lets a 1-cycle memory sustain one instruction per cycle at DEPTH=2.
    assign occupancy = OW'(fifo_count_reg) + OW'(outstanding_reg) - OW'(fifo_pop);
    assign credit_ok = (occupancy < OW'(DEPTH));

    assign imem_req  = credit_ok && !redirect_valid && !rstn;
    assign imem_addr = pc_reg;
    assign req_fire  = imem_req && imem_ready;

    // -------------------------------------------------------------------------
    // Output side
    // -------------------------------------------------------------------------
    assign instr_valid = (fifo_count_reg != '0);
    assign instr_raw   = instr_valid ? fifo_word_mem[fifo_rd_ptr_reg] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_mem[fifo_rd_ptr_reg]   : 32'h0;

    assign fifo_pop  = instr_valid && instr_ready;
    // A response is kept only when it is not stale; a redirect in the same
    // cycle makes it stale as well.
    assign fifo_push = imem_rvalid && (discard_reg == '0) && !redirect_valid;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rvalid);
        discard_next     = discard_reg;
        fifo_count_next  = fifo_count_reg + CW'(fifo_push) - CW'(fifo_pop);
        fifo_wr_ptr_next = fifo_wr_ptr_reg;
        fifo_rd_ptr_next = fifo_rd_ptr_reg;
        pend_wr_ptr_next = pend_wr_ptr_reg;
        pend_rd_ptr_next = pend_rd_ptr_reg;

        if (req_fire) begin
            pc_next          = pc_reg + 32'd4;          // wraps to 0 naturally
            pend_wr_ptr_next = pend_wr_ptr_reg + AW'(1);
        end

        // Every response consumes its pending PC, kept or dropped.
        if (imem_rvalid) begin
            pend_rd_ptr_next = pend_rd_ptr_reg + AW'(1);
            if (discard_reg != '0) begin
                discard_next = discard_reg - CW'(1);
            end
        end

        if (fifo_push) begin
            fifo_wr_ptr_next = fifo_wr_ptr_reg + AW'(1);
        end
        if (fifo_pop) begin
            fifo_rd_ptr_next = fifo_rd_ptr_reg + AW'(1);
        end

        if (redirect_valid) begin
            pc_next          = redirect_pc & 32'hFFFF_FFFC;
            fifo_count_next  = '0;
            fifo_wr_ptr_next = '0;
            fifo_rd_ptr_next = '0;
            // Everything still in flight after this cycle belongs to the old
            // path, so the stale count is simply the new outstanding count.
            discard_next     = outstanding_next;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc_reg          <= RESET_PC & 32'hFFFF_FFFC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            fifo_count_reg  <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
            pend_wr_ptr_reg <= '0;
            pend_rd_ptr_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            fifo_count_reg  <= fifo_count_next;
            fifo_wr_ptr_reg <= fifo_wr_ptr_next;
            fifo_rd_ptr_reg <= fifo_rd_ptr_next;
            pend_wr_ptr_reg <= pend_wr_ptr_next;
            pend_rd_ptr_reg <= pend_rd_ptr_next;
        end
    end

    // Data storage needs no reset: the count and pointers define validity and
    // the outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pend_pc_mem[pend_wr_ptr_reg] <= pc_reg;
        end
        if (fifo_push) begin
            // Latency >= 1 guarantees this pending entry was written earlier.
            fifo_pc_mem[fifo_wr_ptr_reg]   <= pend_pc_mem[pend_rd_ptr_reg];
            fifo_word_mem[fifo_wr_ptr_reg] <= imem_rdata;
        end
    end

    // A response with nothing outstanding means the memory broke the protocol.
    assert property (@(posedge clk) disable iff (rstn)
                     !(imem_rvalid && (outstanding_reg == '0)))
        else $error("fetch_unit: imem_rvalid with no request outstanding");

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural memory with programmable fixed
// latency answers every accepted request with (address ^ xor_key). Expected
// deliveries (pc, word, optional exact cycle) are queued when a step is set up
// and checked in order as the decoder side accepts them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_raw      (instr_raw),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] raw;
        int          cyc;     // -1: any cycle
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    logic [31:0] req_log[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] xor_key = 32'h0;
    logic        force_rdy = 1'b0;
    string       step_tag = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input int c);
        exp_t e;
        e.pc  = pc;
        e.raw = pc ^ xor_key;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        mreq_t m;
        exp_t  e;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            m           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = m.addr ^ xor_key;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        instr_ready = force_rdy || (exp_q.size() > 0);
        #1;
        if (imem_req && imem_ready) begin
            m.addr = imem_addr;
            m.due  = cyc + lat;
            mem_q.push_back(m);
            req_log.push_back(imem_addr);
            $display("[%s] cyc %0d request addr=0x%08h", step_tag, cyc, imem_addr);
        end
        if (instr_valid && instr_ready && !redirect_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("[%s] cyc %0d deliver pc=0x%08h raw=0x%08h", step_tag, cyc, instr_pc, instr_raw);
            chk({step_tag, "_pc"},  instr_pc,  e.pc);
            chk({step_tag, "_raw"}, instr_raw, e.raw);
            if (e.cyc >= 0) begin
                chk({step_tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk({step_tag, "_drained_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Entered at a falling edge; outputs are checked 1 ns after reset assertion.
    task automatic apply_reset();
        rstn           = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        mem_q.delete();
        exp_q.delete();
        #1;
        chk({step_tag, "_rst_req"},   32'(imem_req),    32'd0);
        chk({step_tag, "_rst_valid"}, 32'(instr_valid), 32'd0);
        chk({step_tag, "_rst_pc"},    instr_pc,         32'h0);
        chk({step_tag, "_rst_raw"},   instr_raw,        32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        req_log.delete();
        cyc = 0;
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic kill_pop);
        exp_q.delete();
        req_log.delete();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        force_rdy      = kill_pop;
        $display("[%s] cyc %0d redirect to 0x%08h", step_tag, cyc, target);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        force_rdy      = 1'b0;
    endtask

    initial begin
        rstn           = 1'b1;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);

        // Step 1: streaming with 1-cycle memory, word = address.
        step_tag = "s1";
        lat = 1; xor_key = 32'h0;
        apply_reset();
        exp_push(32'h0, 2);
        exp_push(32'h4, 3);
        exp_push(32'h8, 4);
        exp_push(32'hC, 5);
        drain(20);

        // Step 2: decoder stalled for 10 cycles, then drains.
        step_tag = "s2";
        apply_reset();
        repeat (10) tick();
        chk("s2_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            chk("s2_req0", req_log[0], 32'h0);
            chk("s2_req1", req_log[1], 32'h4);
        end
        #1;
        chk("s2_hold_valid", 32'(instr_valid), 32'd1);
        chk("s2_hold_pc",    instr_pc,         32'h0);
        @(negedge clk);
        exp_push(32'h0, -1);
        exp_push(32'h4, -1);
        exp_push(32'h8, -1);
        drain(20);

        // Step 3: 3-cycle memory, two stale requests in flight at redirect.
        step_tag = "s3";
        lat = 3; xor_key = 32'hDEAD_0000;
        apply_reset();
        repeat (2) tick();
        chk("s3_inflight", 32'(mem_q.size()), 32'd2);
        do_redirect(32'h0000_0100, 1'b0);
        exp_push(32'h100, -1);
        exp_push(32'h104, -1);
        drain(30);

        // Step 4: redirect together with a response and a pop.
        step_tag = "s4";
        lat = 2; xor_key = 32'h5A5A_0000;
        apply_reset();
        repeat (3) tick();
        chk("s4_pre_valid", 32'(instr_valid), 32'd1);
        chk("s4_pre_pc",    instr_pc,         32'h0);
        do_redirect(32'h0000_0300, 1'b1);
        chk("s4_flushed", 32'(instr_valid), 32'd0);
        exp_push(32'h300, -1);
        exp_push(32'h304, -1);
        drain(30);

        // Step 5: misaligned target and address wrap.
        step_tag = "s5";
        lat = 1; xor_key = 32'h0F0F_0000;
        apply_reset();
        tick();
        do_redirect(32'h0000_0203, 1'b0);
        exp_push(32'h200, -1);
        exp_push(32'h204, -1);
        drain(20);
        chk("s5_first_addr", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h200);
        do_redirect(32'hFFFF_FFFC, 1'b0);
        exp_push(32'hFFFF_FFFC, -1);
        exp_push(32'h0, -1);
        exp_push(32'h4, -1);
        drain(20);
        chk("s5_req_count_ge2", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) begin
            chk("s5_wrap_addr0", req_log[0], 32'hFFFF_FFFC);
            chk("s5_wrap_addr1", req_log[1], 32'h0);
        end

        // Step 6: reset while the FIFO is full.
        step_tag = "s6";
        repeat (6) tick();
        #1;
        chk("s6_full_valid", 32'(instr_valid), 32'd1);
        chk("s6_full_pc",    instr_pc,         32'h8);
        @(negedge clk);
        apply_reset();
        exp_push(32'h0, 2);
        exp_push(32'h4, 3);
        drain(20);
        chk("s6_restart_addr", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
